// File: rtl/dcache_wt_pkg.sv
// Shared constants, state encoding and helpers for the write-through data cache.
package dcache_wt_pkg;

    localparam int          DCACHE_INDEX_W = 6;
    localparam logic [31:0] DCACHE_IO_BASE = 32'h0003_0000;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [2:0] LEN_1 = 3'd1;
    localparam logic [2:0] LEN_2 = 3'd2;
    localparam logic [2:0] LEN_4 = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_RESP
    } state_t;

    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            SIZE_B:  return LEN_1;
            SIZE_H:  return LEN_2;
            default: return LEN_4;
        endcase
    endfunction

    // Naturally aligned accesses are the only ones the cache line can serve.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_B:  return 1'b1;
            SIZE_H:  return ~off[0];
            default: return off == 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dcache_wt_load_align.sv
// Selects a byte/half/word from a 32-bit word by byte offset and sign- or
// zero-extends it to 32 bits.
module dcache_wt_load_align
    import dcache_wt_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{off, 3'b000} +: 8];
    assign half_sel = off[1] ? word[31:16] : word[15:0];

    always_comb begin
        // NOTE: default assigned first so every path drives data and no latch is inferred.
        data = word;
        case (size)
            SIZE_B:  data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SIZE_H:  data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache between the MEM
// stage and mem_ctrl, with an uncached I/O window and a whole-cache flush.
module dcache_wt
    import dcache_wt_pkg::*;
#(
    parameter int          INDEX_W  = DCACHE_INDEX_W,
    parameter logic [31:0] IO_BASE  = DCACHE_IO_BASE,
    parameter bit          FLUSH_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_len,
    output logic [31:0] mem_wdata,
    input  logic        mem_busy,
    input  logic        mem_done,
    input  logic [31:0] mem_rdata
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 30 - INDEX_W;

    state_t state, state_n;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_arr  [LINES];
    logic [31:0]      data_arr [LINES];

    logic       flush_pending;
    logic       cached_q;
    logic [1:0] off_q;
    logic [1:0] size_q;
    logic       sign_q;

    logic [INDEX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0]   req_tag, fill_tag;
    logic               flush_req, accept, req_cached, req_hit, fill_we;
    logic [31:0]        line_word, store_word, hit_load, mem_load;

    assign req_idx  = req_addr[INDEX_W+1:2];
    assign req_tag  = req_addr[31:INDEX_W+2];
    // A cached miss latches the word-aligned address, so it also names the fill line.
    assign fill_idx = mem_addr[INDEX_W+1:2];
    assign fill_tag = mem_addr[31:INDEX_W+2];

    assign flush_req  = FLUSH_EN && (flush || flush_pending);
    assign req_ready  = (state == ST_IDLE) && !flush_req;
    assign accept     = req_valid && req_ready && rdy;
    assign req_cached = (req_addr < IO_BASE) && is_aligned(req_size, req_addr[1:0]);
    assign line_word  = data_arr[req_idx];
    assign req_hit    = req_cached && valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
    assign fill_we    = (state == ST_RD_WAIT) && mem_done && cached_q;

    assign resp_valid = (state == ST_RESP);

    // The request state raises mem_req combinationally so the *_WAIT state starts with it.
    always_comb begin
        mem_req = 1'b0;
        case (state)
            ST_RD_REQ, ST_WR_REQ:   mem_req = rdy && !mem_busy;
            ST_RD_WAIT, ST_WR_WAIT: mem_req = 1'b1;
            default:                mem_req = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_we)       state_n = ST_WR_REQ;
                    else if (req_hit) state_n = ST_RESP;
                    else              state_n = ST_RD_REQ;
                end
            end
            ST_RD_REQ:  if (!mem_busy) state_n = ST_RD_WAIT;
            ST_RD_WAIT: if (mem_done)  state_n = ST_RESP;
            ST_WR_REQ:  if (!mem_busy) state_n = ST_WR_WAIT;
            ST_WR_WAIT: if (mem_done)  state_n = ST_RESP;
            ST_RESP:    state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        store_word = line_word;
        case (req_size)
            SIZE_B:  store_word[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
            SIZE_H:  store_word[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
            default: store_word = req_wdata;
        endcase
    end

    dcache_wt_load_align u_hit_align (
        .word     (line_word),
        .off      (req_addr[1:0]),
        .size     (req_size),
        .sign_ext (req_signed),
        .data     (hit_load)
    );

    // Uncached reads come back right-aligned; cached fills are full words.
    dcache_wt_load_align u_mem_align (
        .word     (mem_rdata),
        .off      (cached_q ? off_q : 2'b00),
        .size     (size_q),
        .sign_ext (sign_q),
        .data     (mem_load)
    );

    // NOTE: tag/data arrays are not reset; valid_q alone decides whether a line is usable.
    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            if (accept && req_we && req_hit) begin
                data_arr[req_idx] <= store_word;
            end else if (fill_we) begin
                data_arr[fill_idx] <= mem_rdata;
                tag_arr[fill_idx]  <= fill_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state         <= ST_IDLE;
            valid_q       <= '0;
            flush_pending <= 1'b0;
            resp_rdata    <= '0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_len       <= '0;
            mem_wdata     <= '0;
            cached_q      <= 1'b0;
            off_q         <= '0;
            size_q        <= '0;
            sign_q        <= 1'b0;
        end else if (rdy) begin
            state <= state_n;
            if (state == ST_IDLE) begin
                if (flush_req) begin
                    valid_q       <= '0;
                    flush_pending <= 1'b0;
                end else if (accept) begin
                    cached_q  <= req_cached;
                    off_q     <= req_addr[1:0];
                    size_q    <= req_size;
                    sign_q    <= req_signed;
                    mem_we    <= req_we;
                    mem_addr  <= (req_cached && !req_we) ? {req_addr[31:2], 2'b00} : req_addr;
                    mem_len   <= (req_cached && !req_we) ? LEN_4 : size_to_len(req_size);
                    mem_wdata <= req_we ? req_wdata : '0;
                    if (req_we)       resp_rdata <= '0;
                    else if (req_hit) resp_rdata <= hit_load;
                end
            end else if (FLUSH_EN && flush) begin
                flush_pending <= 1'b1;
            end
            if ((state == ST_RD_WAIT) && mem_done) begin
                resp_rdata <= mem_load;
                if (cached_q) valid_q[fill_idx] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt: vector table of accesses against a small
// mem_ctrl responder, plus hand sequences for busy, rdy, flush and reset.
module tb_dcache_wt;
    import dcache_wt_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        flush, mem_req, mem_we, mem_busy, mem_done;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_len;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        logic        exp_mem;
        logic [31:0] exp_maddr;
        logic [2:0]  exp_len;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    dcache_wt dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_len    (mem_len),
        .mem_wdata  (mem_wdata),
        .mem_busy   (mem_busy),
        .mem_done   (mem_done),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic we, input logic [1:0] sz,
                                input logic sg, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] mr, input logic em, input logic [31:0] ema,
                                input logic [2:0] el, input logic [31:0] er);
        vec_t v;
        v.name = nm; v.we = we; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wd;
        v.mrdata = mr; v.exp_mem = em; v.exp_maddr = ema; v.exp_len = el; v.exp_rdata = er;
        return v;
    endfunction

    task automatic drive_req(input logic we, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
    endtask

    // One access: mem_ctrl answers with mem_done the cycle after it first sees mem_req.
    task automatic access(input vec_t v);
        int          n, done_at, resp_at;
        bit          seen;
        logic [31:0] ga, gw, gr;
        logic [2:0]  gl;
        logic        gwe;
        @(negedge clk);
        drive_req(v.we, v.size, v.sgn, v.addr, v.wdata);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1; done_at = -1; resp_at = -1; seen = 1'b0;
        ga = '0; gw = '0; gr = '0; gl = '0; gwe = 1'b0;
        while (resp_at < 0 && n < 40) begin
            mem_done = 1'b0;
            if (resp_valid) begin
                resp_at = n;
                gr = resp_rdata;
            end else if (mem_req) begin
                if (!seen) begin
                    seen = 1'b1; ga = mem_addr; gl = mem_len; gwe = mem_we; gw = mem_wdata;
                end else if (done_at < 0) begin
                    mem_done = 1'b1; mem_rdata = v.mrdata; done_at = n;
                end
            end
            if (resp_at < 0) begin
                n++;
                @(negedge clk);
            end
        end
        mem_done = 1'b0;
        check($sformatf("%s.mem_req", v.name), {31'b0, seen}, {31'b0, v.exp_mem});
        if (v.exp_mem) begin
            check($sformatf("%s.mem_addr", v.name), ga, v.exp_maddr);
            check($sformatf("%s.mem_len", v.name), {29'b0, gl}, {29'b0, v.exp_len});
            check($sformatf("%s.mem_we", v.name), {31'b0, gwe}, {31'b0, v.we});
            if (v.we) check($sformatf("%s.mem_wdata", v.name), gw, v.wdata);
        end
        check($sformatf("%s.rdata", v.name), gr, v.exp_rdata);
        check($sformatf("%s.latency", v.name), resp_at, v.exp_mem ? 3 : 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SIZE_W;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; flush = 1'b0;
        mem_busy = 1'b0; mem_done = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset.req_ready", {31'b0, req_ready}, 32'd1);
        check("reset.resp_valid", {31'b0, resp_valid}, 32'd0);
        check("reset.resp_rdata", resp_rdata, 32'd0);
        check("reset.mem_req", {31'b0, mem_req}, 32'd0);
        check("reset.mem_we", {31'b0, mem_we}, 32'd0);
        check("reset.mem_addr", mem_addr, 32'd0);
        check("reset.mem_len", {29'b0, mem_len}, 32'd0);
        check("reset.mem_wdata", mem_wdata, 32'd0);

        //              name          we  size    sg  addr          wdata         mrdata        mem maddr         len    rdata
        tbl.push_back(mk("lw_miss",    0, SIZE_W, 0, 32'h0000_1000, 32'h0,        32'hDEAD_BEEF, 1, 32'h0000_1000, LEN_4, 32'hDEAD_BEEF));
        tbl.push_back(mk("lw_hit",     0, SIZE_W, 0, 32'h0000_1000, 32'h0,        32'h0,         0, 32'h0,         LEN_4, 32'hDEAD_BEEF));
        tbl.push_back(mk("sb_hit",     1, SIZE_B, 0, 32'h0000_1001, 32'h0000_007F, 32'h0,        1, 32'h0000_1001, LEN_1, 32'h0));
        tbl.push_back(mk("lb_1001",    0, SIZE_B, 1, 32'h0000_1001, 32'h0,        32'h0,         0, 32'h0,         LEN_1, 32'h0000_007F));
        tbl.push_back(mk("lbu_1003",   0, SIZE_B, 0, 32'h0000_1003, 32'h0,        32'h0,         0, 32'h0,         LEN_1, 32'h0000_00DE));
        tbl.push_back(mk("lh_1002",    0, SIZE_H, 1, 32'h0000_1002, 32'h0,        32'h0,         0, 32'h0,         LEN_2, 32'hFFFF_DEAD));
        tbl.push_back(mk("lb_1000",    0, SIZE_B, 1, 32'h0000_1000, 32'h0,        32'h0,         0, 32'h0,         LEN_1, 32'hFFFF_FFEF));
        tbl.push_back(mk("lhu_1000",   0, SIZE_H, 0, 32'h0000_1000, 32'h0,        32'h0,         0, 32'h0,         LEN_2, 32'h0000_7FEF));
        tbl.push_back(mk("io_lw_a",    0, SIZE_W, 0, 32'h0003_0004, 32'h0,        32'h1234_5678, 1, 32'h0003_0004, LEN_4, 32'h1234_5678));
        tbl.push_back(mk("io_lw_b",    0, SIZE_W, 0, 32'h0003_0004, 32'h0,        32'hCAFE_F00D, 1, 32'h0003_0004, LEN_4, 32'hCAFE_F00D));
        tbl.push_back(mk("io_lh",      0, SIZE_H, 1, 32'h0003_0006, 32'h0,        32'h0000_8001, 1, 32'h0003_0006, LEN_2, 32'hFFFF_8001));
        tbl.push_back(mk("misalign_lh",0, SIZE_H, 1, 32'h0000_1001, 32'h0,        32'h0000_ABCD, 1, 32'h0000_1001, LEN_2, 32'hFFFF_ABCD));
        tbl.push_back(mk("alias_miss", 0, SIZE_W, 0, 32'h0000_1100, 32'h0,        32'h1111_1111, 1, 32'h0000_1100, LEN_4, 32'h1111_1111));
        tbl.push_back(mk("alias_hit",  0, SIZE_W, 0, 32'h0000_1100, 32'h0,        32'h0,         0, 32'h0,         LEN_4, 32'h1111_1111));
        tbl.push_back(mk("evict_miss", 0, SIZE_W, 0, 32'h0000_1000, 32'h0,        32'h2222_2222, 1, 32'h0000_1000, LEN_4, 32'h2222_2222));
        tbl.push_back(mk("sw_miss",    1, SIZE_W, 0, 32'h0000_2040, 32'hA5A5_A5A5, 32'h0,        1, 32'h0000_2040, LEN_4, 32'h0));
        tbl.push_back(mk("no_alloc",   0, SIZE_W, 0, 32'h0000_2040, 32'h0,        32'h3333_3333, 1, 32'h0000_2040, LEN_4, 32'h3333_3333));
        tbl.push_back(mk("sh_hit",     1, SIZE_H, 0, 32'h0000_2042, 32'h0000_BEEF, 32'h0,        1, 32'h0000_2042, LEN_2, 32'h0));
        tbl.push_back(mk("lw_merged",  0, SIZE_W, 0, 32'h0000_2040, 32'h0,        32'h0,         0, 32'h0,         LEN_4, 32'hBEEF_3333));
        tbl.push_back(mk("sw_hit",     1, SIZE_W, 0, 32'h0000_2040, 32'h0102_0304, 32'h0,        1, 32'h0000_2040, LEN_4, 32'h0));
        tbl.push_back(mk("lw_sw_hit",  0, SIZE_W, 0, 32'h0000_2040, 32'h0,        32'h0,         0, 32'h0,         LEN_4, 32'h0102_0304));

        foreach (tbl[i]) access(tbl[i]);

        // mem_busy holds off mem_req; rdy low freezes RD_WAIT even through mem_done.
        @(negedge clk);
        mem_busy = 1'b1;
        drive_req(1'b0, SIZE_W, 1'b0, 32'h0000_3080, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("busy.mem_req_low_%0d", i), {31'b0, mem_req}, 32'd0);
            @(negedge clk);
        end
        mem_busy = 1'b0;
        #1;
        check("busy.mem_req_rise", {31'b0, mem_req}, 32'd1);
        check("busy.mem_addr", mem_addr, 32'h0000_3080);
        @(negedge clk);
        mem_busy = 1'b1;
        rdy = 1'b0;
        #1;
        check("busy.mem_req_held", {31'b0, mem_req}, 32'd1);
        @(negedge clk);
        mem_done = 1'b1; mem_rdata = 32'h9999_9999;
        @(negedge clk);
        mem_done = 1'b0;
        check("rdy.frozen_resp_0", {31'b0, resp_valid}, 32'd0);
        check("rdy.frozen_req_0", {31'b0, mem_req}, 32'd1);
        @(negedge clk);
        check("rdy.frozen_resp_1", {31'b0, resp_valid}, 32'd0);
        check("rdy.frozen_addr", mem_addr, 32'h0000_3080);
        rdy = 1'b1; mem_busy = 1'b0;
        mem_done = 1'b1; mem_rdata = 32'h4444_4444;
        @(negedge clk);
        mem_done = 1'b0;
        check("rdy.resp_valid", {31'b0, resp_valid}, 32'd1);
        check("rdy.resp_rdata", resp_rdata, 32'h4444_4444);

        // Flush concurrent with a request in IDLE.
        access(mk("pre_flush_hit", 0, SIZE_W, 0, 32'h0000_1000, 32'h0, 32'h0, 0, 32'h0, LEN_4, 32'h2222_2222));
        @(negedge clk);
        flush = 1'b1;
        drive_req(1'b0, SIZE_W, 1'b0, 32'h0000_1000, 32'h0);
        #1;
        check("flush.req_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        check("flush.no_accept_resp", {31'b0, resp_valid}, 32'd0);
        check("flush.no_accept_req", {31'b0, mem_req}, 32'd0);
        access(mk("post_flush_miss", 0, SIZE_W, 0, 32'h0000_1000, 32'h0, 32'h7777_7777, 1, 32'h0000_1000, LEN_4, 32'h7777_7777));

        // Flush raised during RESP stays pending and blocks the next acceptance.
        @(negedge clk);
        drive_req(1'b0, SIZE_W, 1'b0, 32'h0000_1000, 32'h0);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b1;
        check("pend.resp_valid", {31'b0, resp_valid}, 32'd1);
        check("pend.resp_rdata", resp_rdata, 32'h7777_7777);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("pend.req_ready", {31'b0, req_ready}, 32'd0);
        access(mk("pend_flush_miss", 0, SIZE_W, 0, 32'h0000_1000, 32'h0, 32'h8888_8888, 1, 32'h0000_1000, LEN_4, 32'h8888_8888));

        // Reset in RD_WAIT aborts without a response.
        @(negedge clk);
        drive_req(1'b0, SIZE_W, 1'b0, 32'h0000_5000, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        check("rstwait.mem_req", {31'b0, mem_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1; mem_done = 1'b1; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        rst = 1'b0; mem_done = 1'b0;
        check("rstwait.mem_req_low", {31'b0, mem_req}, 32'd0);
        check("rstwait.mem_addr", mem_addr, 32'd0);
        check("rstwait.resp_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        check("rstwait.no_resp", {31'b0, resp_valid}, 32'd0);
        check("rstwait.resp_rdata", resp_rdata, 32'd0);
        access(mk("rstwait_miss", 0, SIZE_W, 0, 32'h0000_5000, 32'h0, 32'h6666_6666, 1, 32'h0000_5000, LEN_4, 32'h6666_6666));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
